// File: rtl/b2g_stream_if.sv
// rtl/b2g_stream_if.sv - handshake bundle for the binary-to-Gray stream encoder
interface b2g_stream_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] bin_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] gray_out;
    logic         step_ok;

    // Encoder side: consumes binary words, produces tagged Gray words
    modport slave (
        input  in_valid,
        input  bin_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output gray_out,
        output step_ok
    );

    // Environment side: drives binary words and drains Gray words
    modport master (
        output in_valid,
        output bin_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  gray_out,
        input  step_ok
    );
endinterface

// File: rtl/b2g_stream.sv
// rtl/b2g_stream.sv - streaming binary-to-Gray encoder with 2-entry output buffer and step check
module b2g_stream #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    b2g_stream_if.slave   s
);
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Occupancy 0..2; bit 1 alone means full because 3 is unreachable
    logic [1:0]   count;
    // Head entry drives the outputs directly; tail only holds the second word
    logic [N-1:0] head_gray;
    logic         head_ok;
    logic [N-1:0] tail_gray;
    logic         tail_ok;
    // Last accepted Gray word, the reference for the single-bit-change tag
    logic [N-1:0] prev_gray;

    logic [N-1:0] new_gray;
    logic [N-1:0] diff;
    logic         new_ok;
    logic         acc;
    logic         emit;

    assign new_gray = s.bin_in ^ (s.bin_in >> 1);
    assign diff     = new_gray ^ prev_gray;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign new_ok   = (diff != '0) && ((diff & (diff - ONE)) == '0);

    assign acc  = s.in_valid && !count[1];
    assign emit = s.out_ready && (count != CNT_EMPTY);

    // All outputs come straight from flops so no path exists from out_ready/in_valid
    assign s.in_ready  = !count[1];
    assign s.out_valid = (count != CNT_EMPTY);
    assign s.gray_out  = head_gray;
    assign s.step_ok   = head_ok;

    // Buffer occupancy, entry shifting and reference-word tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= CNT_EMPTY;
            head_gray <= '0;
            head_ok   <= 1'b0;
            tail_gray <= '0;
            tail_ok   <= 1'b0;
            prev_gray <= '0;
        end else begin
            case (count)
                CNT_EMPTY: begin
                    if (acc) begin
                        head_gray <= new_gray;
                        head_ok   <= new_ok;
                        count     <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (acc && emit) begin
                        // Old head leaves, new word takes its place directly
                        head_gray <= new_gray;
                        head_ok   <= new_ok;
                    end else if (acc) begin
                        tail_gray <= new_gray;
                        tail_ok   <= new_ok;
                        count     <= CNT_FULL;
                    end else if (emit) begin
                        // Head keeps its value so gray_out holds while empty
                        count <= CNT_EMPTY;
                    end
                end
                default: begin
                    if (emit) begin
                        head_gray <= tail_gray;
                        head_ok   <= tail_ok;
                        count     <= CNT_ONE;
                    end
                end
            endcase
            if (acc) begin
                prev_gray <= new_gray;
            end
        end
    end
endmodule

// File: tb/tb_b2g_stream.sv
// tb/tb_b2g_stream.sv - self-checking bench for b2g_stream
module tb_b2g_stream;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    b2g_stream_if #(.N(8)) bus ();

    b2g_stream #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] bin;
        logic [7:0] gray;
        logic       ok;
    } vec_t;

    vec_t tbl[9];

    // Reference model: FIFO of {gray, ok}, last reference word, last shown word
    logic [7:0] mq_g[$];
    logic       mq_ok[$];
    logic [7:0] prev_g;
    logic [7:0] last_g;
    logic       last_ok;
    logic [7:0] emitted[$];

    function automatic logic [7:0] enc(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popc(input logic [7:0] x);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq_g.delete();
        mq_ok.delete();
        prev_g  = 8'h00;
        last_g  = 8'h00;
        last_ok = 1'b0;
    endtask

    // One clock: drive, compare against model before the edge, advance model
    task automatic step(input logic v, input logic [7:0] b, input logic r, output logic acc);
        logic       emt;
        logic [7:0] g;
        @(negedge clk);
        bus.in_valid  = v;
        bus.bin_in    = b;
        bus.out_ready = r;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(mq_g.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(mq_g.size() != 2));
        chk("gray_out", 32'(bus.gray_out), 32'((mq_g.size() != 0) ? mq_g[0] : last_g));
        chk("step_ok", 32'(bus.step_ok), 32'((mq_ok.size() != 0) ? mq_ok[0] : last_ok));
        acc = v && (mq_g.size() < 2);
        emt = r && (mq_g.size() != 0);
        @(posedge clk);
        if (emt) begin
            last_g  = mq_g.pop_front();
            last_ok = mq_ok.pop_front();
            emitted.push_back(last_g);
        end
        if (acc) begin
            g = enc(b);
            mq_g.push_back(g);
            mq_ok.push_back(popc(g ^ prev_g) == 1);
            prev_g = g;
        end
        #1;
    endtask

    // Asynchronous assert between edges, synchronous release at a falling edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst gray_out", 32'(bus.gray_out), 32'd0);
        chk("rst step_ok", 32'(bus.step_ok), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic       a;
    logic [7:0] words[20];
    int         sent;
    int         cyc;

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_checks = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.bin_in = 8'h00;
        bus.out_ready = 1'b0;
        model_clear();

        tbl[0] = '{1'b1, 8'h05, 8'h07, 1'b0};
        tbl[1] = '{1'b0, 8'hFF, 8'h80, 1'b0};
        tbl[2] = '{1'b0, 8'h80, 8'hC0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'h01, 8'h01, 1'b1};
        tbl[6] = '{1'b0, 8'h05, 8'h07, 1'b0};
        tbl[7] = '{1'b1, 8'h03, 8'h02, 1'b1};
        tbl[8] = '{1'b0, 8'h03, 8'h02, 1'b0};

        // Table vectors: encoding, first-word and illegal-jump tags
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) do_reset();
            step(1'b1, tbl[i].bin, 1'b1, a);
            chk("tbl gray", 32'(bus.gray_out), 32'(tbl[i].gray));
            chk("tbl ok", 32'(bus.step_ok), 32'(tbl[i].ok));
            chk("tbl valid", 32'(bus.out_valid), 32'd1);
            chk("tbl ready", 32'(bus.in_ready), 32'd1);
        end

        // Counting sequence through wrap, then a repeated word
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            step(1'b1, 8'(i), 1'b1, a);
            chk("count ok", 32'(bus.step_ok), 32'd1);
        end
        step(1'b1, 8'h00, 1'b1, a);
        chk("repeat ok", 32'(bus.step_ok), 32'd0);

        // Backpressure: fill, stall, then drain in order
        do_reset();
        emitted.delete();
        step(1'b1, 8'h01, 1'b0, a);
        step(1'b1, 8'h02, 1'b0, a);
        chk("bp full ready", 32'(bus.in_ready), 32'd0);
        chk("bp stall gray", 32'(bus.gray_out), 32'h01);
        step(1'b1, 8'h03, 1'b0, a);
        chk("bp held acc", 32'(a), 32'd0);
        chk("bp stall gray2", 32'(bus.gray_out), 32'h01);
        step(1'b1, 8'h03, 1'b1, a);
        step(1'b1, 8'h03, 1'b1, a);
        step(1'b0, 8'h00, 1'b1, a);
        step(1'b0, 8'h00, 1'b1, a);
        chk("bp count", 32'(emitted.size()), 32'd3);
        if (emitted.size() == 3) begin
            chk("bp out0", 32'(emitted[0]), 32'h01);
            chk("bp out1", 32'(emitted[1]), 32'h03);
            chk("bp out2", 32'(emitted[2]), 32'h02);
        end

        // Toggling out_ready with continuous input
        do_reset();
        emitted.delete();
        for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
        sent = 0;
        cyc = 0;
        while (sent < 20 && cyc < 100) begin
            step(1'b1, words[sent], (cyc % 2) == 0, a);
            if (a) sent++;
            cyc++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, a);
        chk("toggle count", 32'(emitted.size()), 32'd20);
        if (emitted.size() == 20) begin
            for (int i = 0; i < 20; i++) chk("toggle order", 32'(emitted[i]), 32'(enc(words[i])));
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, a);
        end

        // Reset while full, then first word compares against zero
        step(1'b1, 8'h10, 1'b0, a);
        step(1'b1, 8'h11, 1'b0, a);
        step(1'b1, 8'h12, 1'b0, a);
        chk("pre-rst full", 32'(bus.in_ready), 32'd0);
        do_reset();
        step(1'b1, 8'h03, 1'b1, a);
        chk("post-rst gray", 32'(bus.gray_out), 32'h02);
        chk("post-rst ok", 32'(bus.step_ok), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/b2g_stream.md
Name: b2g_stream

Overview:
- Streaming binary-to-Gray encoder with valid/ready handshakes on both sides and a 2-entry output buffer.
- Generates Gray-coded pointers and counters for clock-domain crossings. The Gray words are decoded back to binary on the far side by the team's Gray-to-binary converter.
- Tags each emitted word with a single-bit-change check so illegal pointer jumps are caught at the source.

Parameters:
- N, 8, data width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  binary word on bin_in is valid.
- in_ready  output  1  block can accept a word this cycle.
- bin_in  input  N  binary input word.
- out_valid  output  1  gray_out/step_ok hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- gray_out  output  N  Gray-coded word at buffer head.
- step_ok  output  1  head word differs from the previously accepted Gray word in exactly one bit.

Behaviour:
- Encoding: gray[N-1] = bin[N-1]; gray[i] = bin[i+1] ^ bin[i] for i = N-2..0, i.e. gray = bin ^ (bin >> 1), unsigned.
- Accept event: in_valid && in_ready at a rising edge. Emit event: out_valid && out_ready at a rising edge.
- Buffer: 2 entries, FIFO order, occupancy count 0..2. Each entry stores {gray, step_ok}.
- in_ready = (count != 2). It is driven from registers only, with no combinational path from out_ready or in_valid.
- out_valid = (count != 0). gray_out and step_ok show the head entry and are driven from registers only.
- Latency: a word accepted at edge k is visible on gray_out after edge k when the buffer was empty (1 cycle).
- Count rules:
  - accept only: count+1.
  - emit only: count-1.
  - accept and emit in the same cycle: count unchanged, head advances, new word enters the tail.
  - When count==1 with simultaneous accept and emit, the new word becomes the head after the edge.
- Full: count==2 drives in_ready=0; in_valid is ignored and bin_in is not sampled.
- Empty: count==0 drives out_valid=0; out_ready is ignored and gray_out holds its last value (0 after reset).
- Stall: while out_valid=1 and out_ready=0, gray_out and step_ok are stable.
- step_ok generation:
  - Register prev_gray is updated with the new Gray word on every accept event.
  - step_ok for a word = (popcount(new_gray ^ prev_gray) == 1).
  - The first word after reset is compared against prev_gray = 0. Therefore bin 0 as first word gives step_ok=0, and bin 1 gives step_ok=1.
  - A repeated identical word gives step_ok=0.
- Wrap-around: bin all-ones followed by 0 is a legal single step, e.g. for N=8 gray 0x80 -> 0x00 gives step_ok=1.
- Reset (asynchronous assert, at any time including mid-transfer):
  - count=0, prev_gray=0, all entries cleared.
  - out_valid=0, gray_out=0, step_ok=0, in_ready=1.
  - Buffered words are discarded.
  - Deassertion is synchronous to clk (assume external synchroniser). The first accept can occur on the first edge with rst_n high.
- No X on outputs after reset regardless of bin_in contents when in_valid=0.

Test Plan:
- Encoding, out_ready=1, N=8: bin 0x05, 0xFF, 0x80, 0x00 in consecutive cycles -> gray_out 0x07, 0x80, 0xC0, 0x00, each 1 cycle after accept, in_ready held 1, out_valid continuous.
- Count sequence after reset: bin 0x01, 0x02, 0x03 ... 0xFF, 0x00 -> step_ok=1 for every word, including 0xFF->0x00 wrap (gray 0x80->0x00). Then bin 0x00 again -> step_ok=0.
- Illegal jump: bin 0x01 then 0x05 (gray 0x01 -> 0x07, two bits differ) -> second word step_ok=0. First word bin 0x00 after reset -> step_ok=0.
- Backpressure: out_ready=0, push 0x01, 0x02, 0x03 on back-to-back cycles -> 0x01 and 0x02 accepted, in_ready=0 from the edge after the second accept, 0x03 held. gray_out stays 0x01 while stalled. Raise out_ready -> outputs 0x01, 0x03 (for 0x02), 0x02 (for 0x03) in order, none lost or duplicated.
- Simultaneous accept/emit at count==1 and count==2: continuous in_valid with out_ready toggling 1,0,1,0 over 20 words -> output order equals input order, count never exceeds 2, in_ready drops only when count==2.
- Reset mid-operation: buffer full (count=2), assert rst_n=0 asynchronously between edges -> out_valid, gray_out, step_ok fall to 0 immediately, in_ready=1. After release, bin 0x03 -> gray_out 0x02, step_ok=1 (compared against 0).
